// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: logical/arithmetic shifts, rotate with BARREL_SHIFT_PIPE_ROTATE_EN.
// Latency SHW cycles, one operand per cycle.
// A stalled output freezes every stage; in_ready = !out_valid || out_ready.
module barrel_shift_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] start,
  input  logic [SHW-1:0]   shift,
  input  logic             right,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  logic w_adv;

  assign in_ready = !out_valid || out_ready;
  assign w_adv    = in_ready;

  for (genvar k = 0; k < SHW; k++) begin : g_stg
    localparam int S  = 1 << k;
    localparam int RW = SHW - k;

    logic             w_vld;
    logic             w_right;
    logic [1:0]       w_mode;
    logic [RW-1:0]    w_sh;
    logic [WIDTH-1:0] w_dat;
    logic [WIDTH-1:0] w_nxt;
    logic [S-1:0]     w_fill;
    logic             r_vld;
    logic [WIDTH-1:0] r_dat;

    if (k == 0) begin : g_src
      assign w_vld   = in_valid;
      assign w_right = right;
      assign w_mode  = mode;
      assign w_sh    = shift;
      assign w_dat   = start;
    end else begin : g_src
      assign w_vld   = g_stg[k-1].r_vld;
      assign w_right = g_stg[k-1].g_fwd.r_right;
      assign w_mode  = g_stg[k-1].g_fwd.r_mode;
      assign w_sh    = g_stg[k-1].g_fwd.r_sh;
      assign w_dat   = g_stg[k-1].r_dat;
    end

    // Arithmetic right keeps the running MSB, which every earlier stage has preserved.
    always_comb begin
      w_fill = {S{(w_mode == 2'b01) && w_right && w_dat[WIDTH-1]}};
      w_nxt  = w_dat;
      if (w_sh[0]) begin
`ifdef BARREL_SHIFT_PIPE_ROTATE_EN
        if (w_mode == 2'b10) begin
          if (w_right) w_nxt = {w_dat[S-1:0], w_dat[WIDTH-1:S]};
          else         w_nxt = {w_dat[WIDTH-S-1:0], w_dat[WIDTH-1:WIDTH-S]};
        end else if (w_right) begin
          w_nxt = {w_fill, w_dat[WIDTH-1:S]};
        end else begin
          w_nxt = {w_dat[WIDTH-S-1:0], {S{1'b0}}};
        end
`else
        if (w_right) w_nxt = {w_fill, w_dat[WIDTH-1:S]};
        else         w_nxt = {w_dat[WIDTH-S-1:0], {S{1'b0}}};
`endif
      end
    end

    always_ff @(posedge clk) begin
      if (rst)        r_vld <= 1'b0;
      else if (w_adv) r_vld <= w_vld;
    end

    if (k == SHW - 1) begin : g_last
      // Bubbles load zero so no stale data reaches result.
      always_ff @(posedge clk) begin
        if (rst)        r_dat <= '0;
        else if (w_adv) r_dat <= w_vld ? w_nxt : '0;
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (w_adv) r_dat <= w_nxt;
      end
    end

    if (k < SHW - 1) begin : g_fwd
      logic          r_right;
      logic [1:0]    r_mode;
      logic [RW-2:0] r_sh;

      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_right <= w_right;
          r_mode  <= w_mode;
          r_sh    <= w_sh[RW-1:1];
        end
      end
    end
  end

  assign out_valid = g_stg[SHW-1].r_vld;
  assign result    = g_stg[SHW-1].r_dat;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Scoreboard bench for barrel_shift_pipe at WIDTH=8 and WIDTH=32.
module tb_barrel_shift_pipe;

  localparam bit ROT =
`ifdef BARREL_SHIFT_PIPE_ROTATE_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    logic [31:0] exp;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [7:0] s;
    logic [2:0] sh;
    logic       r;
    logic [1:0] m;
    logic [7:0] e;
  } vec8_t;

  typedef struct {
    logic [31:0] s;
    logic [4:0]  sh;
    logic        r;
    logic [1:0]  m;
    logic [31:0] e;
  } vec32_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic       in_valid8 = 1'b0, in_ready8, right8 = 1'b0, out_valid8, out_ready8 = 1'b1;
  logic [7:0] start8 = '0, result8;
  logic [2:0] shift8 = '0;
  logic [1:0] mode8 = '0;

  logic        in_valid32 = 1'b0, in_ready32, right32 = 1'b0, out_valid32, out_ready32 = 1'b1;
  logic [31:0] start32 = '0, result32;
  logic [4:0]  shift32 = '0;
  logic [1:0]  mode32 = '0;

  exp_t q8[$];
  exp_t q32[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  barrel_shift_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .start(start8), .shift(shift8), .right(right8), .mode(mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8)
  );

  barrel_shift_pipe #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .start(start32), .shift(shift32), .right(right32), .mode(mode32),
    .out_valid(out_valid32), .out_ready(out_ready32), .result(result32)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance with in_valid still high.
  task automatic send8(input logic [7:0] s, input logic [2:0] sh, input logic r,
                       input logic [1:0] m, input logic [7:0] e, input int lat);
    int   t = 0;
    exp_t x;
    start8 = s; shift8 = sh; right8 = r; mode8 = m; in_valid8 = 1'b1;
    #1;
    while (!in_ready8 && t < 50) begin
      @(negedge clk); #1; t++;
    end
    if (!in_ready8) begin
      check("send8 accept timeout", {31'b0, in_ready8}, 32'd1);
    end else begin
      x.exp = {24'b0, e}; x.acc = cyc; x.lat = lat;
      q8.push_back(x);
    end
    @(negedge clk);
  endtask

  task automatic send32(input logic [31:0] s, input logic [4:0] sh, input logic r,
                        input logic [1:0] m, input logic [31:0] e, input int lat);
    int   t = 0;
    exp_t x;
    start32 = s; shift32 = sh; right32 = r; mode32 = m; in_valid32 = 1'b1;
    #1;
    while (!in_ready32 && t < 50) begin
      @(negedge clk); #1; t++;
    end
    if (!in_ready32) begin
      check("send32 accept timeout", {31'b0, in_ready32}, 32'd1);
    end else begin
      x.exp = e; x.acc = cyc; x.lat = lat;
      q32.push_back(x);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while ((q8.size() != 0 || q32.size() != 0) && t < 100) begin
      @(negedge clk); t++;
    end
    check("drain q8 empty", q8.size(), 32'd0);
    check("drain q32 empty", q32.size(), 32'd0);
  endtask

  initial begin : mon8
    bit   pend = 1'b0;
    int   app = 0;
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (rst || !out_valid8) begin
        pend = 1'b0;
      end else begin
        if (!pend) begin pend = 1'b1; app = cyc; end
        if (out_ready8) begin
          if (q8.size() == 0) begin
            check("w8 unexpected out_valid", {31'b0, out_valid8}, 32'd0);
          end else begin
            e = q8.pop_front();
            check("w8 result", {24'b0, result8}, e.exp);
            if (e.lat >= 0) check("w8 latency", app - e.acc, e.lat);
          end
          pend = 1'b0;
        end
      end
    end
  end

  initial begin : mon32
    bit   pend = 1'b0;
    int   app = 0;
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (rst || !out_valid32) begin
        pend = 1'b0;
      end else begin
        if (!pend) begin pend = 1'b1; app = cyc; end
        if (out_ready32) begin
          if (q32.size() == 0) begin
            check("w32 unexpected out_valid", {31'b0, out_valid32}, 32'd0);
          end else begin
            e = q32.pop_front();
            check("w32 result", result32, e.exp);
            if (e.lat >= 0) check("w32 latency", app - e.acc, e.lat);
          end
          pend = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec8_t  v8[12];
    vec32_t v32[7];

    v8[0]  = '{8'hF0, 3'd2, 1'b1, 2'b00, 8'h3C};
    v8[1]  = '{8'hF0, 3'd2, 1'b0, 2'b00, 8'hC0};
    v8[2]  = '{8'hC0, 3'd2, 1'b1, 2'b01, 8'hF0};
    v8[3]  = '{8'h03, 3'd1, 1'b1, 2'b10, ROT ? 8'h81 : 8'h01};
    v8[4]  = '{8'h81, 3'd1, 1'b0, 2'b10, ROT ? 8'h03 : 8'h02};
    v8[5]  = '{8'hF0, 3'd4, 1'b1, 2'b11, 8'h0F};
    v8[6]  = '{8'h80, 3'd7, 1'b1, 2'b01, 8'hFF};
    v8[7]  = '{8'h96, 3'd5, 1'b0, 2'b01, 8'hC0};
    v8[8]  = '{8'hA5, 3'd0, 1'b1, 2'b01, 8'hA5};
    v8[9]  = '{8'hA5, 3'd0, 1'b0, 2'b10, 8'hA5};
    v8[10] = '{8'h5A, 3'd3, 1'b1, 2'b00, 8'h0B};
    v8[11] = '{8'hB4, 3'd3, 1'b1, 2'b10, ROT ? 8'h96 : 8'h16};

    v32[0] = '{32'h80000001, 5'd31, 1'b0, 2'b00, 32'h80000000};
    v32[1] = '{32'h80000001, 5'd31, 1'b1, 2'b01, 32'hFFFFFFFF};
    v32[2] = '{32'h12345678, 5'd16, 1'b1, 2'b10, ROT ? 32'h56781234 : 32'h00001234};
    v32[3] = '{32'h7FFFFFFF, 5'd4,  1'b1, 2'b01, 32'h07FFFFFF};
    v32[4] = '{32'hDEADBEEF, 5'd0,  1'b0, 2'b01, 32'hDEADBEEF};
    v32[5] = '{32'hF0000000, 5'd8,  1'b1, 2'b11, 32'h00F00000};
    v32[6] = '{32'h80000001, 5'd1,  1'b0, 2'b10, ROT ? 32'h00000003 : 32'h00000002};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset out_valid8", {31'b0, out_valid8}, 32'd0);
    check("reset result8", {24'b0, result8}, 32'd0);
    check("reset in_ready8", {31'b0, in_ready8}, 32'd1);
    check("reset out_valid32", {31'b0, out_valid32}, 32'd0);
    check("reset result32", result32, 32'd0);
    @(negedge clk);

    // Isolated operands separated by bubbles
    send8(8'hF0, 3'd2, 1'b1, 2'b00, 8'h3C, 3);
    in_valid8 = 1'b0;
    @(negedge clk);
    send8(8'hF0, 3'd2, 1'b0, 2'b00, 8'hC0, 3);
    in_valid8 = 1'b0;
    repeat (2) @(negedge clk);
    send8(8'hC0, 3'd2, 1'b1, 2'b01, 8'hF0, 3);
    in_valid8 = 1'b0;
    drain();

    // Back-to-back burst at full throughput
    for (int i = 0; i < 12; i++) send8(v8[i].s, v8[i].sh, v8[i].r, v8[i].m, v8[i].e, 3);
    in_valid8 = 1'b0;
    drain();

    // Output stall for 4 cycles with a fourth operand waiting
    send8(8'h11, 3'd1, 1'b0, 2'b00, 8'h22, 3);
    send8(8'h81, 3'd3, 1'b1, 2'b01, 8'hF0, -1);
    send8(8'h3C, 3'd2, 1'b1, 2'b00, 8'h0F, -1);
    out_ready8 = 1'b0;
    start8 = 8'h01; shift8 = 3'd7; right8 = 1'b0; mode8 = 2'b00; in_valid8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall out_valid8", {31'b0, out_valid8}, 32'd1);
      check("stall result8", {24'b0, result8}, 32'h22);
      check("stall in_ready8", {31'b0, in_ready8}, 32'd0);
      @(negedge clk);
    end
    out_ready8 = 1'b1;
    send8(8'h01, 3'd7, 1'b0, 2'b00, 8'h80, 3);
    in_valid8 = 1'b0;
    drain();

    // Reset with three operands in flight
    send8(8'hAA, 3'd1, 1'b0, 2'b00, 8'h54, 3);
    send8(8'h55, 3'd1, 1'b1, 2'b00, 8'h2A, 3);
    send8(8'h0F, 3'd4, 1'b0, 2'b00, 8'hF0, 3);
    out_ready8 = 1'b0;
    in_valid8 = 1'b0;
    rst = 1'b1;
    q8.delete();
    q32.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-rst out_valid8", {31'b0, out_valid8}, 32'd0);
    check("post-rst result8", {24'b0, result8}, 32'd0);
    @(negedge clk);
    out_ready8 = 1'b1;
    repeat (8) @(negedge clk);
    send8(8'h0F, 3'd1, 1'b1, 2'b00, 8'h07, 3);
    in_valid8 = 1'b0;
    drain();

    // WIDTH=32 burst
    for (int i = 0; i < 7; i++) send32(v32[i].s, v32[i].sh, v32[i].r, v32[i].m, v32[i].e, 5);
    in_valid32 = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
